// File: rtl/dtree_frame_ctrl_pkg.sv
// Shared types, default widths and sizing helper for the decision-tree frame controller.
package dtree_ctrl_pkg;

    localparam int unsigned DEF_FEAT_W       = 8;
    localparam int unsigned DEF_CLASS_W      = 5;
    localparam int unsigned DEF_NUM_FEATURES = 5;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_EVAL = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/dtree_frame_ctrl_if.sv
// Feature stream in / class result out handshake bundle for dtree_frame_ctrl.
interface dtree_frame_if
    import dtree_ctrl_pkg::*;
#(
    parameter int unsigned FEAT_W  = DEF_FEAT_W,
    parameter int unsigned CLASS_W = DEF_CLASS_W
) ();

    logic              s_valid;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data;
    logic              s_last;

    logic               m_valid;
    logic               m_ready;
    logic [CLASS_W-1:0] m_class;

    // Controller side: consumes features, produces the class.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class
    );

    // Front-end/host side.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class
    );

endinterface

// File: rtl/dtree_frame_ctrl_feat_regfile.sv
// Write-indexed feature register bank presenting all features as one flat bus.
module dtree_feat_regfile
    import dtree_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FEATURES = DEF_NUM_FEATURES,
    parameter int unsigned FEAT_W       = DEF_FEAT_W,
    parameter int unsigned IDX_W        = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_we,
    input  logic [IDX_W-1:0]               i_idx,
    input  logic [FEAT_W-1:0]              i_data,
    output logic [NUM_FEATURES*FEAT_W-1:0] o_flat
);

    logic [NUM_FEATURES-1:0][FEAT_W-1:0] r_feat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat <= '0;
        end else begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                if (i_we && (i_idx == IDX_W'(i))) r_feat[i] <= i_data;
            end
        end
    end

    assign o_flat = r_feat;

endmodule

// File: rtl/dtree_frame_ctrl.sv
// Frame loader and settle/capture sequencer for a slow combinational decision tree.
// Optional macro DTREE_FRAME_TIMEOUT_EN aborts a partial frame after TIMEOUT_CYC idle cycles.
module dtree_frame_ctrl
    import dtree_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FEATURES  = DEF_NUM_FEATURES,
    parameter int unsigned FEAT_W        = DEF_FEAT_W,
    parameter int unsigned CLASS_W       = DEF_CLASS_W,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYC   = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    dtree_frame_if.slave                   bus,
    output logic [NUM_FEATURES*FEAT_W-1:0] feat_flat,
    input  logic [CLASS_W-1:0]             cls_in,
    output logic                           busy,
    output logic                           frame_err
);

    localparam int unsigned IDX_W = clog2_min1(NUM_FEATURES);
    localparam int unsigned CNT_W = clog2_min1(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_s_ready, r_busy;
    logic               r_m_valid, w_m_valid_nxt;
    logic [CLASS_W-1:0] r_m_class, w_m_class_nxt;
    logic               r_frame_err, w_frame_err_nxt;
    logic               w_xfer;

`ifdef DTREE_FRAME_TIMEOUT_EN
    localparam int unsigned GAP_W = clog2_min1(TIMEOUT_CYC + 1);
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

    // s_ready is only ever high in LOAD, so it alone qualifies a transfer.
    assign w_xfer = bus.s_valid && r_s_ready;

    dtree_feat_regfile #(
        .NUM_FEATURES (NUM_FEATURES),
        .FEAT_W       (FEAT_W),
        .IDX_W        (IDX_W)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_xfer),
        .i_idx  (r_idx),
        .i_data (bus.s_data),
        .o_flat (feat_flat)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_m_valid_nxt   = r_m_valid;
        w_m_class_nxt   = r_m_class;
        w_frame_err_nxt = 1'b0;
`ifdef DTREE_FRAME_TIMEOUT_EN
        w_gap_nxt       = r_gap;
`endif
        case (r_state)
            ST_LOAD: begin
                if (w_xfer) begin
`ifdef DTREE_FRAME_TIMEOUT_EN
                    w_gap_nxt = '0;
`endif
                    if (bus.s_last && (r_idx == LAST_IDX)) begin
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = ST_EVAL;
                    end else if (bus.s_last || (r_idx == LAST_IDX)) begin
                        w_frame_err_nxt = 1'b1;
                        w_idx_nxt       = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
`ifdef DTREE_FRAME_TIMEOUT_EN
                // Idle gap inside a partially received frame.
                else if (r_idx != '0) begin
                    if (r_gap == GAP_W'(TIMEOUT_CYC - 1)) begin
                        w_frame_err_nxt = 1'b1;
                        w_idx_nxt       = '0;
                        w_gap_nxt       = '0;
                    end else begin
                        w_gap_nxt = r_gap + GAP_W'(1);
                    end
                end
`endif
            end
            ST_EVAL: begin
                if (r_cnt == '0) begin
                    w_m_class_nxt = cls_in;
                    w_m_valid_nxt = 1'b1;
                    w_state_nxt   = ST_OUT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    w_m_valid_nxt = 1'b0;
                    w_state_nxt   = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_s_ready   <= 1'b0;
            r_busy      <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_class   <= '0;
            r_frame_err <= 1'b0;
`ifdef DTREE_FRAME_TIMEOUT_EN
            r_gap       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_s_ready   <= (w_state_nxt == ST_LOAD);
            r_busy      <= (w_state_nxt != ST_LOAD);
            r_m_valid   <= w_m_valid_nxt;
            r_m_class   <= w_m_class_nxt;
            r_frame_err <= w_frame_err_nxt;
`ifdef DTREE_FRAME_TIMEOUT_EN
            r_gap       <= w_gap_nxt;
`endif
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_class = r_m_class;
    assign busy        = r_busy;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_dtree_frame_ctrl.sv
// Self-checking bench for dtree_frame_ctrl: frame-level reference model plus directed literal checks.
module tb_dtree_frame_ctrl;

    localparam int NF     = 5;
    localparam int FW     = 8;
    localparam int CW     = 5;
    localparam int SETTLE = 2;
`ifdef DTREE_FRAME_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NF*FW-1:0] feat_flat;
    logic [CW-1:0]    cls_in;
    logic             busy, frame_err;

    int checks     = 0;
    int failures   = 0;
    int err_pulses = 0;

    dtree_frame_if #(.FEAT_W(FW), .CLASS_W(CW)) bus ();

    dtree_frame_ctrl #(
        .NUM_FEATURES  (NF),
        .FEAT_W        (FW),
        .CLASS_W       (CW),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .feat_flat (feat_flat),
        .cls_in    (cls_in),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Stub tree: class is the low bits of feature 0.
    assign cls_in = feat_flat[CW-1:0];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level reference model: bytes gathered, settle countdown, pending result.
    logic [FW-1:0] m_feat [NF];
    int            m_cnt, m_eval_left, m_idle;
    bit            m_res_valid, m_err, m_rdy;
    logic [CW-1:0] m_res_class;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NF; i++) m_feat[i] = '0;
                m_cnt = 0; m_eval_left = 0; m_idle = 0;
                m_res_valid = 0; m_err = 0; m_rdy = 0; m_res_class = '0;
            end else begin
                bit acc;
                acc   = bus.s_valid && m_rdy;
                m_err = 0;
                if (m_res_valid) begin
                    if (bus.m_ready) m_res_valid = 0;
                end else if (m_eval_left > 0) begin
                    m_eval_left--;
                    if (m_eval_left == 0) begin
                        m_res_valid = 1;
                        m_res_class = m_feat[0][CW-1:0];
                    end
                end else if (acc) begin
                    m_feat[m_cnt] = bus.s_data;
                    m_cnt++;
                    m_idle = 0;
                    if (bus.s_last && m_cnt == NF) begin
                        m_eval_left = SETTLE;
                        m_cnt = 0;
                    end else if (bus.s_last || m_cnt == NF) begin
                        m_err = 1;
                        m_cnt = 0;
                    end
                end else begin
`ifdef DTREE_FRAME_TIMEOUT_EN
                    if (m_cnt > 0) begin
                        m_idle++;
                        if (m_idle == TO) begin
                            m_err = 1; m_cnt = 0; m_idle = 0;
                        end
                    end
`endif
                end
                m_rdy = (m_eval_left == 0) && !m_res_valid;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            logic [NF*FW-1:0] exp_flat;
            @(posedge clk);
            #2;
            for (int i = 0; i < NF; i++) exp_flat[i*FW +: FW] = m_feat[i];
            chk("cyc_s_ready",   64'(bus.s_ready), 64'(m_rdy));
            chk("cyc_m_valid",   64'(bus.m_valid), 64'(m_res_valid));
            chk("cyc_m_class",   64'(bus.m_class), 64'(m_res_class));
            chk("cyc_busy",      64'(busy),        64'((m_eval_left > 0) || m_res_valid));
            chk("cyc_frame_err", 64'(frame_err),   64'(m_err));
            chk("cyc_feat_flat", 64'(feat_flat),   64'(exp_flat));
            if (frame_err) err_pulses++;
        end
    end

    task automatic send_byte(input logic [FW-1:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("s_ready_wait_timeout", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_good(input logic [FW-1:0] b0);
        send_byte(b0,    1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h7F, 1'b0);
        send_byte(8'h05, 1'b1);
    endtask

    // Edges counted from the edge that opened the final-byte cycle.
    task automatic wait_result(output int lat);
        int n = 1;
        while (!bus.m_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("m_valid_wait_timeout", 64'(bus.m_valid), 64'd1);
        lat = n;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int lat;
        int errs0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_s_ready",   64'(bus.s_ready), 64'd0);
        chk("rst_m_valid",   64'(bus.m_valid), 64'd0);
        chk("rst_m_class",   64'(bus.m_class), 64'd0);
        chk("rst_busy",      64'(busy),        64'd0);
        chk("rst_feat_flat", 64'(feat_flat),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

        // Good frame with immediate sink acceptance.
        send_good(8'h13);
        chk("good_busy", 64'(busy), 64'd1);
        wait_result(lat);
        chk("good_latency", 64'(lat), 64'd3);
        chk("good_class",   64'(bus.m_class), 64'h13);
        chk("good_flat",    64'(feat_flat), 64'h05_7F_40_22_13);
        @(posedge clk);
        #1;
        chk("good_m_valid_drop", 64'(bus.m_valid), 64'd0);
        chk("good_s_ready_back", 64'(bus.s_ready), 64'd1);

        // Sink backpressure for 20 cycles.
        bus.m_ready = 1'b0;
        send_good(8'h13);
        wait_result(lat);
        chk("bp_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid",   64'(bus.m_valid), 64'd1);
            chk("bp_hold_class",   64'(bus.m_class), 64'h13);
            chk("bp_hold_s_ready", 64'(bus.s_ready), 64'd0);
        end
        @(negedge clk);
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid",   64'(bus.m_valid), 64'd0);
        chk("bp_release_s_ready", 64'(bus.s_ready), 64'd1);

        // Early last on the third byte.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        chk("early_err_pulse", 64'(frame_err), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("early_err_low", 64'(frame_err), 64'd0);
            chk("early_no_valid", 64'(bus.m_valid), 64'd0);
        end
        send_good(8'h09);
        wait_result(lat);
        chk("early_next_class", 64'(bus.m_class), 64'h09);
        @(posedge clk);
        #1;

        // Missing last: five bytes, none flagged last.
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h35, 1'b0);
        chk("miss_err_pulse", 64'(frame_err), 64'd1);
        chk("miss_no_valid",  64'(bus.m_valid), 64'd0);
        send_good(8'h1A);
        wait_result(lat);
        chk("miss_next_latency", 64'(lat), 64'd3);
        chk("miss_next_class",   64'(bus.m_class), 64'h1A);
        @(posedge clk);
        #1;

        // Reset while evaluating.
        send_good(8'h15);
        chk("rst_eval_busy_before", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_eval_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_eval_busy",    64'(busy),        64'd0);
        chk("rst_eval_flat",    64'(feat_flat),   64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_good(8'h0C);
        wait_result(lat);
        chk("rst_after_class", 64'(bus.m_class), 64'h0C);
        @(posedge clk);
        #1;

`ifdef DTREE_FRAME_TIMEOUT_EN
        // Partial frame abandoned for TO idle cycles.
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (TO - 1) @(posedge clk);
        #2;
        chk("to_no_err_early", 64'(frame_err), 64'd0);
        @(posedge clk);
        #2;
        chk("to_err_pulse", 64'(frame_err), 64'd1);
        // Gap one short of the limit must not abort.
        errs0 = err_pulses;
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        repeat (TO - 1) @(posedge clk);
        send_byte(8'h13, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h15, 1'b1);
        wait_result(lat);
        chk("to_short_gap_no_err", 64'(err_pulses - errs0), 64'd0);
        chk("to_short_gap_class",  64'(bus.m_class), 64'h11);
        @(posedge clk);
        #1;
`else
        // A partial frame waits indefinitely without error.
        errs0 = err_pulses;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (300) @(posedge clk);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b1);
        wait_result(lat);
        chk("long_gap_no_err", 64'(err_pulses - errs0), 64'd0);
        chk("long_gap_class",  64'(bus.m_class), 64'h01);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
